// File: rtl/shift_rotate_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_unit_pkg
// Brief    : Shared op codes, amount-width derivation and FSM state encoding
//            for the multi-cycle shift/rotate unit.
// Revision : 1.0 - initial release
// ============================================================================
package shift_rotate_unit_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ROR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_SRL  = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  // One extra bit so that the amount can express WIDTH itself.
  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_rotate_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_unit_if
// Brief    : Command/response bundle between the control FSM and the shared
//            shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_rotate_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic             sin;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] po;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, sin, pin,
    input  po, sout, busy, done
  );

  modport slave (
    input  start, op, amt, sin, pin,
    output po, sout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_rotate_unit_shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Brief    : Combinational single step (1 or 2 positions) of a rotate or
//            logical/arithmetic shift, including fill and wrap bits.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [2:0]       op,
  input  wire logic [WIDTH-1:0] po,
  input  wire logic [1:0]       step,
  input  wire logic             sin,
  output logic      [WIDTH-1:0] po_next,
  output logic                  out_bit
);

  logic w_two;
  logic w_msb;

  assign w_two = step[1];
  assign w_msb = po[WIDTH-1];

  // Move the register by one or two positions; two-position steps fill both
  // vacated bits with the same fill value.
  always_comb begin
    po_next = po;
    out_bit = 1'b0;
    case (op)
      OP_ROR: begin
        po_next = w_two ? {po[1:0], po[WIDTH-1:2]} : {po[0], po[WIDTH-1:1]};
        out_bit = w_two ? po[1] : po[0];
      end
      OP_ROL: begin
        po_next = w_two ? {po[WIDTH-3:0], po[WIDTH-1:WIDTH-2]} : {po[WIDTH-2:0], po[WIDTH-1]};
        out_bit = w_two ? po[WIDTH-2] : po[WIDTH-1];
      end
      OP_SRL: begin
        po_next = w_two ? {sin, sin, po[WIDTH-1:2]} : {sin, po[WIDTH-1:1]};
        out_bit = w_two ? po[1] : po[0];
      end
      OP_SLL: begin
        po_next = w_two ? {po[WIDTH-3:0], sin, sin} : {po[WIDTH-2:0], sin};
        out_bit = w_two ? po[WIDTH-2] : po[WIDTH-1];
      end
      OP_SRA: begin
        po_next = w_two ? {w_msb, w_msb, po[WIDTH-1:2]} : {w_msb, po[WIDTH-1:1]};
        out_bit = w_two ? po[1] : po[0];
      end
      default: begin
        po_next = po;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_rotate_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_unit
// Brief    : Multi-cycle WIDTH-bit load/rotate/shift register moving at most
//            two positions per clock, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rotate_unit
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  shift_rotate_unit_if.slave bus
);

  state_t           r_state, w_state_next;
  logic [2:0]       r_op, w_op_next;
  logic [AMT_W-1:0] r_rem, w_rem_next;
  logic [WIDTH-1:0] r_po, w_po_next;
  logic             r_sout, w_sout_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;

  logic [AMT_W-1:0] w_amt_clamp;
  logic [AMT_W-1:0] w_step;
  logic [AMT_W-1:0] w_rem_after;
  logic             w_is_move;
  logic [WIDTH-1:0] w_step_po;
  logic             w_step_out;

  // Amounts beyond the register width behave exactly like WIDTH.
  assign w_amt_clamp = (bus.amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amt;
  assign w_is_move   = (bus.op >= OP_ROR) && (bus.op <= OP_SRA);
  assign w_step      = (r_rem >= AMT_W'(2)) ? AMT_W'(2) : AMT_W'(1);
  assign w_rem_after = r_rem - w_step;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .op      (r_op),
    .po      (r_po),
    .step    (w_step[1:0]),
    .sin     (bus.sin),
    .po_next (w_step_po),
    .out_bit (w_step_out)
  );

  // Next-state and datapath update: accept in IDLE, step in RUN.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_rem_next   = r_rem;
    w_po_next    = r_po;
    w_sout_next  = r_sout;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_op_next  = bus.op;
          w_rem_next = w_amt_clamp;
          if (bus.op == OP_LOAD) begin
            w_po_next   = bus.pin;
            w_done_next = 1'b1;
          end else if (w_is_move && (w_amt_clamp != '0)) begin
            w_state_next = RUN;
            w_busy_next  = 1'b1;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        w_po_next   = w_step_po;
        w_sout_next = w_step_out;
        w_rem_next  = w_rem_after;
        if (w_rem_after == '0) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_rem   <= '0;
      r_po    <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_rem   <= w_rem_next;
      r_po    <= w_po_next;
      r_sout  <= w_sout_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.po   = r_po;
  assign bus.sout = r_sout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_rotate_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rotate_unit
// Brief    : Scoreboard bench: directed commands push expected results, a
//            monitor pops and checks on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rotate_unit;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_ROR  = 3'd2;
  localparam logic [2:0] C_ROL  = 3'd3;
  localparam logic [2:0] C_SRL  = 3'd4;
  localparam logic [2:0] C_SLL  = 3'd5;
  localparam logic [2:0] C_SRA  = 3'd6;

  typedef struct {
    logic [7:0] po;
    logic       sout;
    int         busy_cycles;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_checks;
  int   n_fail;
  int   busy_cnt;

  shift_rotate_unit_if #(.WIDTH(8)) bus ();

  shift_rotate_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_result(input string name, input logic [7:0] po, input logic sout, input int bc);
    exp_t e;
    e.name = name;
    e.po = po;
    e.sout = sout;
    e.busy_cycles = bc;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] p, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.amt   = a;
    bus.pin   = p;
    bus.sin   = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after 40 cycles, expected 0", name);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse, with busy-cycle count.
  initial begin
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else if (bus.done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with po=0x%0h, expected no done", bus.po);
        end else begin
          e = q.pop_front();
          check({e.name, "_po"}, int'(bus.po), int'(e.po));
          check({e.name, "_sout"}, int'(bus.sout), int'(e.sout));
          check({e.name, "_busy_cycles"}, busy_cnt, e.busy_cycles);
          check({e.name, "_busy_at_done"}, int'(bus.busy), 0);
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = C_NOP;
    bus.amt   = '0;
    bus.pin   = '0;
    bus.sin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_po", int'(bus.po), 0);
    check("reset_sout", int'(bus.sout), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    rst = 1'b0;

    expect_result("load_b4", 8'hB4, 1'b0, 0);
    issue(C_LOAD, 4'd0, 8'hB4, 1'b0);
    wait_idle("load_b4");

    expect_result("ror3", 8'h96, 1'b1, 2);
    issue(C_ROR, 4'd3, 8'h00, 1'b0);
    wait_idle("ror3");

    // A LOAD pulsed while busy must be ignored.
    expect_result("sra5", 8'hFC, 1'b1, 3);
    issue(C_SRA, 4'd5, 8'h00, 1'b0);
    bus.start = 1'b1;
    bus.op    = C_LOAD;
    bus.pin   = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("sra5");

    expect_result("load_00", 8'h00, 1'b1, 0);
    issue(C_LOAD, 4'd0, 8'h00, 1'b0);
    wait_idle("load_00");

    expect_result("sll8", 8'hFF, 1'b0, 4);
    issue(C_SLL, 4'd8, 8'h00, 1'b1);
    wait_idle("sll8");

    expect_result("load_5a", 8'h5A, 1'b0, 0);
    issue(C_LOAD, 4'd0, 8'h5A, 1'b0);
    wait_idle("load_5a");

    expect_result("rol12", 8'h5A, 1'b0, 4);
    issue(C_ROL, 4'd12, 8'h00, 1'b0);
    wait_idle("rol12");

    // Zero-amount rotate, with start held so the next command is accepted
    // on the done cycle.
    expect_result("ror0", 8'h5A, 1'b0, 0);
    expect_result("rol2_b2b", 8'h69, 1'b1, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = C_ROR;
    bus.amt   = 4'd0;
    @(negedge clk);
    check("ror0_done_next_cycle", int'(bus.done), 1);
    bus.op  = C_ROL;
    bus.amt = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_no_bubble", int'(bus.busy), 1);
    wait_idle("rol2_b2b");

    // Reset during the second step of SRL 6 aborts without done.
    issue(C_SRL, 4'd6, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("srl6_step1_po", int'(bus.po), 8'h1A);
    check("srl6_step1_busy", int'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_po", int'(bus.po), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_sout", int'(bus.sout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    expect_result("load_81", 8'h81, 1'b0, 0);
    issue(C_LOAD, 4'd0, 8'h81, 1'b0);
    wait_idle("load_81");

    expect_result("sll1", 8'h02, 1'b1, 1);
    issue(C_SLL, 4'd1, 8'h00, 1'b0);
    wait_idle("sll1");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
